// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch-stage load/run sequencer.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        FC_LOAD  = 2'd0,
        FC_START = 2'd1,
        FC_RUN   = 2'd2,
        FC_FAULT = 2'd3
    } fetch_ctrl_state_e;

    localparam int unsigned INST_BYTES = 32'd4;
    localparam logic [1:0]  ALIGN_MASK = 2'b11;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Load stream, run-mode control and fetch-port signals of fetch_ctrl.
// The reload signal exists only when FETCH_CTRL_RELOAD_EN is defined.
interface fetch_ctrl_if #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
);
    logic            load_valid;
    logic [ILEN-1:0] load_data;
    logic            load_last;
    logic            load_ready;
    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] wdata;
    logic            write_en;
    logic            fetch_valid;
    logic            fault;
`ifdef FETCH_CTRL_RELOAD_EN
    logic            reload;

    modport master (
        output load_valid, load_data, load_last, stall, redirect_valid, redirect_pc, reload,
        input  load_ready, pc, wdata, write_en, fetch_valid, fault
    );
    modport slave (
        input  load_valid, load_data, load_last, stall, redirect_valid, redirect_pc, reload,
        output load_ready, pc, wdata, write_en, fetch_valid, fault
    );
`else
    modport master (
        output load_valid, load_data, load_last, stall, redirect_valid, redirect_pc,
        input  load_ready, pc, wdata, write_en, fetch_valid, fault
    );
    modport slave (
        input  load_valid, load_data, load_last, stall, redirect_valid, redirect_pc,
        output load_ready, pc, wdata, write_en, fetch_valid, fault
    );
`endif
endinterface

// File: rtl/fetch_pc_next.sv
// Run-mode next-PC selection: redirect beats stall beats sequential +4,
// plus detection of a misaligned redirect target.
module fetch_pc_next
    import fetch_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc_q,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc_next,
    output logic            misalign
);

    // Priority mux and alignment test.
    always_comb begin
        pc_next  = pc_q;
        misalign = 1'b0;
        if (redirect_valid) begin
            pc_next  = redirect_pc;
            misalign = ((redirect_pc[1:0] & ALIGN_MASK) != 2'b00);
        end else if (stall) begin
            pc_next  = pc_q;
        end else begin
            pc_next  = pc_q + XLEN'(INST_BYTES);
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: loads a program into the fetch memory, then generates
// fetch PCs. Optional reload-from-run/fault is enabled by FETCH_CTRL_RELOAD_EN.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter int              ILEN       = 32,
    parameter int              PROG_WORDS = 256,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic         clock,
    input  logic         reset_n,
    fetch_ctrl_if.slave  bus
);

    localparam int CW = $clog2(PROG_WORDS);

    fetch_ctrl_state_e state_r;
    logic [CW-1:0]     cnt_r;
    logic [XLEN-1:0]   pc_q_r;
    logic              load_ready_r;
    logic              fault_r;

    logic              handshake_s;
    logic              last_s;
    logic              reload_s;
    logic [XLEN-1:0]   pc_next_s;
    logic              misalign_s;
    logic [ILEN-1:0]   wdata_s;

`ifdef FETCH_CTRL_RELOAD_EN
    assign reload_s = bus.reload;
`else
    assign reload_s = 1'b0;
`endif

    // A word at the last slot closes the load even without load_last.
    assign handshake_s = bus.load_valid & (state_r == FC_LOAD);
    assign last_s      = handshake_s & (bus.load_last | (cnt_r == CW'(PROG_WORDS - 1)));
    assign wdata_s     = bus.load_data;

    fetch_pc_next #(.XLEN(XLEN)) u_pc_next (
        .pc_q           (pc_q_r),
        .stall          (bus.stall),
        .redirect_valid (bus.redirect_valid),
        .redirect_pc    (bus.redirect_pc),
        .pc_next        (pc_next_s),
        .misalign       (misalign_s)
    );

    // Fetch-port drive: write port during load, fetch address afterwards.
    always_comb begin
        bus.wdata       = wdata_s;
        bus.write_en    = handshake_s;
        bus.load_ready  = load_ready_r;
        bus.fault       = fault_r;
        bus.pc          = pc_q_r;
        bus.fetch_valid = 1'b0;
        case (state_r)
            FC_LOAD:  bus.pc = XLEN'({cnt_r, 2'b00});
            FC_RUN:   bus.fetch_valid = ~bus.stall;
            FC_START: bus.pc = pc_q_r;
            FC_FAULT: bus.pc = pc_q_r;
            default:  bus.pc = pc_q_r;
        endcase
    end

    // Sequencer state, word counter, fetch PC and registered status flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= FC_LOAD;
            cnt_r        <= '0;
            pc_q_r       <= RESET_PC;
            load_ready_r <= 1'b1;
            fault_r      <= 1'b0;
        end else begin
            case (state_r)
                FC_LOAD: begin
                    if (handshake_s) begin
                        cnt_r <= cnt_r + CW'(1);
                        if (last_s) begin
                            state_r      <= FC_START;
                            load_ready_r <= 1'b0;
                        end
                    end
                end
                FC_START: begin
                    pc_q_r  <= RESET_PC;
                    state_r <= FC_RUN;
                end
                FC_RUN: begin
                    if (reload_s) begin
                        state_r      <= FC_LOAD;
                        cnt_r        <= '0;
                        load_ready_r <= 1'b1;
                    end else if (misalign_s) begin
                        // Keep the last good PC visible while faulted.
                        state_r <= FC_FAULT;
                        fault_r <= 1'b1;
                    end else begin
                        pc_q_r <= pc_next_s;
                    end
                end
                FC_FAULT: begin
                    if (reload_s) begin
                        state_r      <= FC_LOAD;
                        cnt_r        <= '0;
                        load_ready_r <= 1'b1;
                        fault_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= FC_LOAD;
                    cnt_r        <= '0;
                    load_ready_r <= 1'b1;
                    fault_r      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencer for the fetch stage's instruction memory port. After reset it runs a program-load phase: it accepts instruction words over a valid/ready stream and drives the shared `pc`/`wdata`/`write_en` port of the fetch stage so each word is written to consecutive word addresses. It then switches to run mode, where it generates the fetch `pc` each cycle, honouring stall and branch/jump redirect requests from downstream. It sits directly in front of `fetch` and owns that block's `pc`, `wdata` and `write_en` inputs.

## Interface
- `XLEN`, 32, address/PC width
- `ILEN`, 32, instruction width
- `PROG_WORDS`, 256, maximum words accepted in one load phase (≥2)
- `RESET_PC`, 0, first fetch address in run mode; word aligned

- `clock`  in  1  single clock; all state updates on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `load_valid`  in  1  load word present
- `load_data`  in  ILEN  load word
- `load_last`  in  1  qualifies the final load word
- `load_ready`  out  1  controller accepts load words
- `stall`  in  1  hold current fetch PC
- `redirect_valid`  in  1  replace next PC with `redirect_pc`
- `redirect_pc`  in  XLEN  redirect target
- `pc`  out  XLEN  to `fetch.pc`: write address in load, fetch address in run
- `wdata`  out  ILEN  to `fetch.wdata`
- `write_en`  out  1  to `fetch.write_en`
- `fetch_valid`  out  1  `pc` is a valid fetch this cycle
- `fault`  out  1  misaligned redirect captured; sticky
- `reload`  in  1  only when `FETCH_CTRL_RELOAD_EN` is defined

## Operation
- States: LOAD, START, RUN, FAULT. Reset → LOAD, word count `cnt` = 0, `pc_q` = `RESET_PC`.
- LOAD: `load_ready` = 1. Handshake = `load_valid & load_ready`. `pc` = `cnt*4`, `wdata` = `load_data`, `write_en` = handshake. On handshake, `cnt` increments. Go to START on a handshake with `load_last`, or on the handshake at `cnt == PROG_WORDS-1`, which is treated as last. No valid → hold, no write.
- START: one bubble cycle. `load_ready` = 0, `write_en` = 0, `fetch_valid` = 0, `pc_q` ← `RESET_PC`. Go to RUN.
- RUN: `pc` = `pc_q`, `fetch_valid` = `!stall`, `write_en` = 0, `load_ready` = 0.
  - Next `pc_q` priority: `redirect_valid` (even when `stall` = 1) → `redirect_pc`; else `stall` → hold; else `pc_q + 4`, wrapping modulo 2^XLEN.
  - `redirect_valid` with `redirect_pc[1:0] != 0` → FAULT. `pc_q` is not updated.
- FAULT: `fault` = 1, `fetch_valid` = 0, `pc` holds the last good `pc_q`. Exit only via reset, or `reload` if compiled in.
- `wdata` = `load_data` in every state; it is qualified only by `write_en`.
- Reset values of outputs: `load_ready` = 1, `write_en` = 0 (load_valid low assumed at reset), `pc` = 0, `fetch_valid` = 0, `fault` = 0.

## Timing
- Load handshake has zero latency: the write occurs at the same edge the word is accepted. `pc`/`wdata`/`write_en` are combinational from `cnt` and `load_*`.
- Last word accepted at edge N → START during cycle N+1 → first fetch of `RESET_PC` with `fetch_valid` = 1 in cycle N+2.
- Redirect sampled at edge N → `pc` = target in cycle N+1.
- Stall affects the current cycle's `fetch_valid` combinationally. It holds `pc_q` at the next edge.
- An asynchronous reset mid-load abandons the load: `cnt` = 0, and already-written words are not erased.

## Configuration
- `FETCH_CTRL_RELOAD_EN` defined: `reload` port exists. A `reload` pulse in RUN or FAULT → LOAD at the next edge, with `cnt` = 0 and `fault` cleared. `reload` has priority over redirect. It is ignored in LOAD and START.
- Not defined: no `reload` port. LOAD is reachable only through `reset_n`.

## Structure
- Package `fetch_ctrl_pkg`:
  - `fetch_ctrl_state_e` enum {FC_LOAD, FC_START, FC_RUN, FC_FAULT}
  - `INST_BYTES` = 4
  - `ALIGN_MASK` = 2'b11
- Sub-module `fetch_pc_next`: combinational next-PC priority mux and misalignment detect. Inputs: `pc_q`, `stall`, `redirect_valid`, `redirect_pc`. Outputs: `pc_next`, `misalign`.
- `cnt` width is `$clog2(PROG_WORDS)`.

## Test plan
- Load 3 words 0x00500093, 0x00100113, 0x002081B3, with `load_last` on the third → writes at `pc` 0, 4, 8. First `fetch_valid` 2 cycles after the last handshake, with `pc` = 0.
- `load_valid` toggling 1,0,1,1 with `load_last` on the final word → exactly 3 writes at 0, 4, 8. No write on the idle cycle.
- Load `PROG_WORDS` words without `load_last` → the final write is at `(PROG_WORDS-1)*4`, then START then RUN.
- RUN: `stall` for 2 cycles at `pc` = 0x8 → `pc` stays 0x8 with `fetch_valid` = 0, then 0xC. Simultaneous `stall` and redirect to 0x40 → next `pc` = 0x40.
- Redirect to 0x42 → FAULT. `fault` = 1, `fetch_valid` = 0, `pc` holds. With RELOAD_EN, a `reload` pulse → `load_ready` = 1 and `fault` = 0 next cycle.
- Assert `reset_n` = 0 mid-load after 2 words → asynchronous return to LOAD. Next load starts at `pc` 0.
